// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: pixel source placed directly after the VGA timing generator.
// It renders one of four test patterns through a fixed two-stage pipeline, so
// rgb lags disp_ena/col/row by exactly two clocks.
//
// Ports:
//   clk        pixel clock, rising edge
//   rst_n      asynchronous active-low reset
//   disp_ena   active-video flag from the timing generator
//   col, row   active-area coordinates; ignored while disp_ena is low
//   mode_req   requested pattern (0 solid, 1 bars, 2 checker, 3 moving box)
//   solid_rgb  {R,G,B} colour for the solid pattern and for the box fill
//   rgb        {R,G,B} pixel data; forced to zero outside active video
//   pix_valid  rgb carries an active pixel (disp_ena delayed by two clocks)
//   frame_done one-cycle pulse presented together with the last active pixel
//   frame_cnt  completed-frame count, wraps 255 -> 0
//   mode_act   pattern currently in effect; changes only at end of frame
module vga_pattern_gen #(
   parameter int unsigned H_BITS    = 7,
   parameter int unsigned V_BITS    = 5,
   parameter int unsigned COLS      = 50,
   parameter int unsigned ROWS      = 25,
   parameter int unsigned CH_W      = 4,
   parameter int unsigned BOX_W     = 8,
   parameter int unsigned BOX_H     = 4,
   parameter int unsigned BAR_SHIFT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                disp_ena,
   input  logic [H_BITS-1:0]   col,
   input  logic [V_BITS-1:0]   row,
   input  logic [1:0]          mode_req,
   input  logic [3*CH_W-1:0]   solid_rgb,
   output logic [3*CH_W-1:0]   rgb,
   output logic                pix_valid,
   output logic                frame_done,
   output logic [7:0]          frame_cnt,
   output logic [1:0]          mode_act
);

   localparam int unsigned RGB_W = 3 * CH_W;

   localparam logic [H_BITS-1:0] LAST_COL  = H_BITS'(COLS - 1);
   localparam logic [V_BITS-1:0] LAST_ROW  = V_BITS'(ROWS - 1);
   localparam logic [H_BITS-1:0] BOX_MAX   = H_BITS'(COLS - BOX_W);
   localparam logic [H_BITS:0]   BOX_W_EXT = (H_BITS + 1)'(BOX_W);
   localparam logic [V_BITS-1:0] BOX_H_V   = V_BITS'(BOX_H);
   localparam logic [H_BITS-1:0] BAR_SAT   = H_BITS'(7);

   // Stage 1: registered raster inputs
   logic              s1_ena_q;
   logic [H_BITS-1:0] s1_col_q;
   logic [V_BITS-1:0] s1_row_q;
   logic              s1_eof_q;

   // Frame-level state, updated only when the eof pixel sits in stage 1
   logic [1:0]        mode_act_q;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic [H_BITS-1:0] box_x_q, box_x_d;

   // Stage 2: registered outputs
   logic [RGB_W-1:0]  rgb_q, rgb_d;
   logic              pix_valid_q;
   logic              frame_done_q;

   logic              eof_in;
   logic [H_BITS-1:0] bar_full;
   logic [2:0]        bar;
   logic [H_BITS:0]   box_end;
   logic              in_box;
   logic [RGB_W-1:0]  pat;

   // Out-of-range coordinates never match, so they cannot end a frame
   assign eof_in = disp_ena && (col == LAST_COL) && (row == LAST_ROW);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_ena_q <= 1'b0;
         s1_col_q <= '0;
         s1_row_q <= '0;
         s1_eof_q <= 1'b0;
      end else begin
         s1_ena_q <= disp_ena;
         s1_col_q <= col;
         s1_row_q <= row;
         s1_eof_q <= eof_in;
      end
   end

   always_comb begin
      bar_full = s1_col_q >> BAR_SHIFT;
      bar      = (bar_full > BAR_SAT) ? 3'd7 : bar_full[2:0];
      // One extra bit so the box end cannot wrap near the right edge
      box_end  = {1'b0, box_x_q} + BOX_W_EXT;
      in_box   = (s1_col_q >= box_x_q) && ({1'b0, s1_col_q} < box_end) &&
                 (s1_row_q < BOX_H_V);

      pat = '0;
      unique case (mode_act_q)
         2'd0: pat = solid_rgb;
         2'd1: pat = {{CH_W{bar[2]}}, {CH_W{bar[1]}}, {CH_W{bar[0]}}};
         2'd2: pat = (s1_col_q[2] ^ s1_row_q[2]) ? {RGB_W{1'b1}} : '0;
         2'd3: pat = in_box ? solid_rgb : '0;
      endcase

      rgb_d = s1_ena_q ? pat : '0;
   end

   always_comb begin
      frame_cnt_d = frame_cnt_q + 8'd1;
      box_x_d     = (box_x_q == BOX_MAX) ? '0 : box_x_q + 1'b1;
   end

   // The stage-2 pixel of the eof pixel is rendered on this same edge from the
   // pre-update mode/box, which keeps every frame single-pattern.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_act_q  <= 2'd0;
         frame_cnt_q <= 8'd0;
         box_x_q     <= '0;
      end else if (s1_eof_q) begin
         mode_act_q  <= mode_req;
         frame_cnt_q <= frame_cnt_d;
         box_x_q     <= box_x_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q        <= '0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         rgb_q        <= rgb_d;
         pix_valid_q  <= s1_ena_q;
         frame_done_q <= s1_eof_q;
      end
   end

   assign rgb        = rgb_q;
   assign pix_valid  = pix_valid_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign mode_act   = mode_act_q;

endmodule
